// File: rtl/mul_i4_o4_err_monitor.sv
// Sweeps all 16 input vectors of a 2x2 approximate multiplier and accumulates error statistics against the exact product.
// Latency: done pulses 17 cycles after start is sampled; start is ignored outside IDLE, approx_out is sampled combinationally every SWEEP cycle.
module mul_i4_o4_err_monitor #(
  parameter int ET = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] approx_out,
  output logic [3:0] stim,
  output logic       busy,
  output logic       done,
  output logic [3:0] max_err,
  output logic [7:0] err_sum,
  output logic [4:0] viol_cnt,
  output logic [3:0] first_fail,
  output logic       fail_seen,
  output logic       pass
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [31:0] ET_U = ET;

  state_t     state;
  logic [3:0] exact;
  logic [3:0] err;
  logic       viol;

  // Operands are 2 bits each, so the product (max 9) always fits in 4 bits.
  assign exact = {2'b00, stim[1:0]} * {2'b00, stim[3:2]};
  assign err   = (exact >= approx_out) ? (exact - approx_out) : (approx_out - exact);
  assign viol  = ({28'd0, err} > ET_U);

  assign busy = (state == SWEEP);
  assign done = (state == DONE);
  assign pass = (viol_cnt == 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      stim       <= 4'd0;
      max_err    <= 4'd0;
      err_sum    <= 8'd0;
      viol_cnt   <= 5'd0;
      first_fail <= 4'd0;
      fail_seen  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= SWEEP;
            stim       <= 4'd0;
            max_err    <= 4'd0;
            err_sum    <= 8'd0;
            viol_cnt   <= 5'd0;
            first_fail <= 4'd0;
            fail_seen  <= 1'b0;
          end
        end
        SWEEP: begin
          if (err > max_err) max_err <= err;
          err_sum <= err_sum + {4'd0, err};
          if (viol) begin
            viol_cnt <= viol_cnt + 5'd1;
            if (!fail_seen) begin
              first_fail <= stim;
              fail_seen  <= 1'b1;
            end
          end
          // stim wraps 15 -> 0 on its own as the sweep ends.
          stim <= stim + 4'd1;
          if (stim == 4'd15) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_i4_o4_err_monitor.sv
// Directed bench for mul_i4_o4_err_monitor: expected sweep statistics are queued at start and checked when done pulses.
module tb_mul_i4_o4_err_monitor;

  typedef struct {
    logic [3:0] max_err;
    logic [7:0] err_sum;
    logic [4:0] viol_cnt;
    logic [3:0] first_fail;
    logic       fail_seen;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [3:0] approx_out;
  logic [3:0] stim;
  logic       busy, done;
  logic [3:0] max_err;
  logic [7:0] err_sum;
  logic [4:0] viol_cnt;
  logic [3:0] first_fail;
  logic       fail_seen, pass;

  int   mode = 0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];

  mul_i4_o4_err_monitor #(.ET(2)) dut (
    .clk(clk), .rst(rst), .start(start), .approx_out(approx_out),
    .stim(stim), .busy(busy), .done(done), .max_err(max_err),
    .err_sum(err_sum), .viol_cnt(viol_cnt), .first_fail(first_fail),
    .fail_seen(fail_seen), .pass(pass)
  );

  always #5 clk = ~clk;

  // Multiplier under test: 0 = exact, 1 = stuck at 0, 2 = stuck at 15.
  always_comb begin
    case (mode)
      1:       approx_out = 4'd0;
      2:       approx_out = 4'd15;
      default: approx_out = {2'b00, stim[1:0]} * {2'b00, stim[3:2]};
    endcase
  end

  function automatic exp_t model(input int m);
    exp_t e;
    int a, b, p, ap, d;
    e.max_err = 0; e.err_sum = 0; e.viol_cnt = 0; e.first_fail = 0; e.fail_seen = 0;
    for (int s = 0; s < 16; s++) begin
      a  = s % 4;
      b  = s / 4;
      p  = a * b;
      ap = (m == 1) ? 0 : (m == 2) ? 15 : p;
      d  = (p > ap) ? p - ap : ap - p;
      if (d > e.max_err) e.max_err = 4'(d);
      e.err_sum = e.err_sum + 8'(d);
      if (d > 2) begin
        e.viol_cnt = e.viol_cnt + 5'd1;
        if (!e.fail_seen) begin
          e.first_fail = 4'(s);
          e.fail_seen  = 1'b1;
        end
      end
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_result();
    exp_t e;
    if (q.size() == 0) begin
      chk("scoreboard_empty_at_done", 32'd1, 32'd0);
    end else begin
      e = q.pop_front();
      chk("max_err", max_err, e.max_err);
      chk("err_sum", err_sum, e.err_sum);
      chk("viol_cnt", viol_cnt, e.viol_cnt);
      chk("fail_seen", fail_seen, e.fail_seen);
      if (e.fail_seen) chk("first_fail", first_fail, e.first_fail);
      chk("pass", pass, (e.viol_cnt == 0));
    end
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_stim"}, stim, 0);
    chk({tag, "_max_err"}, max_err, 0);
    chk({tag, "_err_sum"}, err_sum, 0);
    chk({tag, "_viol_cnt"}, viol_cnt, 0);
    chk({tag, "_first_fail"}, first_fail, 0);
    chk({tag, "_fail_seen"}, fail_seen, 0);
    chk({tag, "_pass"}, pass, 1);
  endtask

  // Pulse start, optionally pulse it again mid-sweep, and expect done in cycle 17.
  task automatic run_sweep(input int m, input int mid);
    bit got;
    mode = m;
    q.push_back(model(m));
    start = 1'b1;
    cyc = 0;
    step();
    start = 1'b0;
    chk("busy_c1", busy, 1);
    chk("stim_c1", stim, 0);
    got = 0;
    while (!got && cyc < 40) begin
      start = (cyc == mid);
      step();
      if (done) got = 1;
      else if (cyc <= 16) chk("stim_seq", stim, cyc - 1);
    end
    start = 1'b0;
    chk("done_cycle", cyc, 17);
    if (got) check_result();
    step();
    chk("c18_busy", busy, 0);
    chk("c18_done", done, 0);
    chk("c18_held_sum", err_sum, model(m).err_sum);
  endtask

  initial begin
    int dn[$];
    int n;

    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_cleared("reset");

    run_sweep(0, -1);
    run_sweep(1, 5);
    run_sweep(2, -1);

    // Abort a sweep with reset once stim reaches 9, then run a clean one.
    mode = 1;
    start = 1'b1;
    cyc = 0;
    step();
    start = 1'b0;
    n = 0;
    while (stim != 4'd9 && n < 20) begin
      step();
      n++;
    end
    chk("abort_at_stim9", stim, 9);
    chk("abort_fail_seen_before_rst", fail_seen, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_cleared("mid_rst");
    step();
    chk("mid_rst_idle_busy", busy, 0);
    run_sweep(1, -1);

    // start held high for 40 cycles: back-to-back sweeps.
    mode = 0;
    q.push_back(model(0));
    q.push_back(model(0));
    start = 1'b1;
    cyc = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (done) begin
        dn.push_back(cyc);
        check_result();
      end
      if (cyc == 18 || cyc == 36) chk("b2b_gap_busy", busy, 0);
    end
    start = 1'b0;
    chk("b2b_done_count", dn.size(), 2);
    if (dn.size() >= 2) begin
      chk("b2b_done0", dn[0], 17);
      chk("b2b_done1", dn[1], 35);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_cleared("final_rst");
    chk("scoreboard_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mul_i4_o4_err_monitor.md
MUL_I4_O4_ERR_MONITOR -- requirements
Module: mul_i4_o4_err_monitor

Interface
REQ-001: Parameter ET, default 2, is the error threshold; an absolute error greater than ET counts as a violation.
REQ-002: clk  input  1  single clock; all state updates on its rising edge.
REQ-003: rst  input  1  synchronous, active-high reset.
REQ-004: start  input  1  requests one exhaustive sweep; sampled only in IDLE.
REQ-005: approx_out  input  4  response of the approximate 2x2 multiplier under test, produced combinationally from stim; bit i is out_i.
REQ-006: stim  output  4  registered stimulus to the multiplier; bit i drives in_i; operand A = stim[1:0], operand B = stim[3:2].
REQ-007: busy  output  1  high while in SWEEP.
REQ-008: done  output  1  one-cycle pulse when a sweep completes.
REQ-009: max_err  output  4  largest absolute error seen in the current or last sweep.
REQ-010: err_sum  output  8  sum of absolute errors over the sweep.
REQ-011: viol_cnt  output  5  number of vectors with error > ET (0..16).
REQ-012: first_fail  output  4  stim value of the first violating vector; valid only when fail_seen=1.
REQ-013: fail_seen  output  1  at least one violation in the sweep.
REQ-014: pass  output  1  combinational, equal to (viol_cnt == 0).

Function
REQ-015: The exact reference is 4-bit unsigned exact = A*B (range 0..9), computed internally.
REQ-016: err = |exact - approx_out|, a 4-bit unsigned value (0..15); no saturation is needed.
REQ-017: The FSM has three states, IDLE, SWEEP and DONE, binary encoded.
REQ-018: IDLE with start=1: next state SWEEP; stim, max_err, err_sum, viol_cnt, first_fail and fail_seen all cleared to 0.
REQ-019: IDLE with start=0: the FSM stays in IDLE and every output register holds its value.
REQ-020: SWEEP, each cycle: evaluate err for the current stim and approx_out in the same cycle, then register the updates.
  - max_err <= max(max_err, err).
  - err_sum <= err_sum + err.
  - viol_cnt increments when err > ET.
  - On the first violation (fail_seen=0): first_fail <= stim and fail_seen <= 1.
REQ-021: SWEEP stim sequencing: stim increments by 1 each cycle; when stim == 15 has been evaluated, stim wraps to 0 and the next state is DONE.
REQ-022: The sweep lasts exactly 16 SWEEP cycles; err_sum cannot overflow (max 240).
REQ-023: start is ignored while in SWEEP or DONE.
REQ-024: DONE: done=1 for exactly one cycle, next state IDLE, and all statistics are held.
REQ-025: Latency: start sampled at edge 0 → stim=0 in cycle 1 → done=1 in cycle 17 → IDLE in cycle 18.
REQ-026: If start stays high, a new sweep begins on the edge leaving cycle 18, so sweeps run back-to-back with one IDLE cycle between them.
REQ-027: busy = (state == SWEEP); done = (state == DONE); both are decoded from registered state.

Reset
REQ-028: rst=1 at a rising edge forces IDLE and sets all of the following to 0: stim, max_err, err_sum, viol_cnt, first_fail and fail_seen.
REQ-029: Reset overrides start and any in-progress sweep, including in the DONE cycle.
REQ-030: After reset, busy=0, done=0 and pass=1.

Verification
REQ-031: approx_out tied to the exact product, start pulsed → done in cycle 17, max_err=0, err_sum=0, viol_cnt=0, fail_seen=0, pass=1.
REQ-032: approx_out tied to 0 (ET=2) → max_err=9, err_sum=36, viol_cnt=6, first_fail=7, fail_seen=1, pass=0.
REQ-033: approx_out tied to 15 → max_err=15, err_sum=204, viol_cnt=16, first_fail=0, pass=0.
REQ-034: rst asserted when stim=9 during a sweep → the next cycle is IDLE with all outputs 0 and busy=0; a later start runs a full, correct sweep.
REQ-035: start held high for 40 cycles with the exact model → done pulses in cycles 17 and 35, and busy is low in cycles 18 and 36.
REQ-036: start pulsed in cycle 5 during a sweep → no effect, and done still occurs in cycle 17.
